// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-ported memory,
// one transaction at a time, with a bounded wait for the memory ready handshake.
module mem_port_arbiter #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halted,
   input  logic        if_req,
   input  logic [29:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [29:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [29:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } state_t;

   localparam logic       PORT_FETCH = 1'b0;
   localparam logic       PORT_DATA  = 1'b1;
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic        last_r, last_s;
   logic        m_req_r, m_req_s;
   logic        m_we_r, m_we_s;
   logic [29:0] m_addr_r, m_addr_s;
   logic [31:0] m_wdata_r, m_wdata_s;
   logic        if_ack_r, if_ack_s, if_err_r, if_err_s;
   logic        d_ack_r, d_ack_s, d_err_r, d_err_s;
   logic [31:0] if_rdata_r, if_rdata_s, d_rdata_r, d_rdata_s;
   logic        fetch_ok_s, data_ok_s;

   // A requester being acknowledged this cycle must not be granted again on the same edge.
   assign fetch_ok_s = if_req & ~halted & ~if_ack_r;
   assign data_ok_s  = d_req & ~d_ack_r;

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      last_s     = last_r;
      m_req_s    = m_req_r;
      m_we_s     = m_we_r;
      m_addr_s   = m_addr_r;
      m_wdata_s  = m_wdata_r;
      if_ack_s   = 1'b0;
      if_err_s   = 1'b0;
      d_ack_s    = 1'b0;
      d_err_s    = 1'b0;
      if_rdata_s = if_rdata_r;
      d_rdata_s  = d_rdata_r;
      case (state_r)
         ST_IDLE: begin
            if (fetch_ok_s && (!data_ok_s || (last_r == PORT_DATA))) begin
               state_s   = ST_FETCH;
               cnt_s     = 8'd0;
               last_s    = PORT_FETCH;
               m_req_s   = 1'b1;
               m_we_s    = 1'b0;
               m_addr_s  = if_addr;
               m_wdata_s = 32'd0;
            end else if (data_ok_s) begin
               state_s   = ST_DATA;
               cnt_s     = 8'd0;
               last_s    = PORT_DATA;
               m_req_s   = 1'b1;
               m_we_s    = d_we;
               m_addr_s  = d_addr;
               m_wdata_s = d_wdata;
            end else begin
               m_req_s = 1'b0;
            end
         end
         ST_FETCH, ST_DATA: begin
            // Ready on the limit cycle still counts as a normal completion.
            if (m_ready || (cnt_r == WAIT_LIMIT)) begin
               state_s = ST_IDLE;
               m_req_s = 1'b0;
               m_we_s  = 1'b0;
               if (state_r == ST_FETCH) begin
                  if_ack_s   = 1'b1;
                  if_err_s   = ~m_ready;
                  if_rdata_s = m_ready ? m_rdata : 32'd0;
               end else begin
                  d_ack_s = 1'b1;
                  d_err_s = ~m_ready;
                  if (!m_we_r) begin
                     d_rdata_s = m_ready ? m_rdata : 32'd0;
                  end else begin
                     d_rdata_s = d_rdata_r;
                  end
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            m_req_s = 1'b0;
            m_we_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 8'd0;
         last_r     <= PORT_DATA;
         m_req_r    <= 1'b0;
         m_we_r     <= 1'b0;
         m_addr_r   <= 30'd0;
         m_wdata_r  <= 32'd0;
         if_ack_r   <= 1'b0;
         if_err_r   <= 1'b0;
         d_ack_r    <= 1'b0;
         d_err_r    <= 1'b0;
         if_rdata_r <= 32'd0;
         d_rdata_r  <= 32'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         last_r     <= last_s;
         m_req_r    <= m_req_s;
         m_we_r     <= m_we_s;
         m_addr_r   <= m_addr_s;
         m_wdata_r  <= m_wdata_s;
         if_ack_r   <= if_ack_s;
         if_err_r   <= if_err_s;
         d_ack_r    <= d_ack_s;
         d_err_r    <= d_err_s;
         if_rdata_r <= if_rdata_s;
         d_rdata_r  <= d_rdata_s;
      end
   end

   assign m_req    = m_req_r;
   assign busy     = m_req_r;
   assign m_we     = m_we_r;
   assign m_addr   = m_addr_r;
   assign m_wdata  = m_wdata_r;
   assign if_ack   = if_ack_r;
   assign if_err   = if_err_r;
   assign d_ack    = d_ack_r;
   assign d_err    = d_err_r;
   assign if_rdata = if_rdata_r;
   assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants and acks,
// a negedge monitor compares them as the DUT presents them.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halted = 1'b0;
   logic        if_req = 1'b0;
   logic [29:0] if_addr = 30'd0;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [29:0] d_addr = 30'd0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = 32'd0;
   logic        m_ready = 1'b0;
   logic        busy;

   mem_port_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
      bit          chk_wdata;
      int          gap;
   } grant_t;

   typedef struct {
      bit          is_data;
      logic        err;
      logic [31:0] rdata;
      int          len;
   } ack_t;

   grant_t gq[$];
   ack_t   aq[$];
   int     total = 0;
   int     passed = 0;
   int     cyc = 0;
   int     rise_cyc = 0;
   int     last_ack_cyc = 0;
   int     ready_at = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      else passed++;
   endtask

   task automatic bad(string name);
      total++;
      $display("FAIL %s: event with nothing expected at cycle %0d", name, cyc);
   endtask

   task automatic exp_grant(logic we, logic [29:0] addr, logic [31:0] wdata, bit chkw, int gap);
      grant_t g;
      g.we = we; g.addr = addr; g.wdata = wdata; g.chk_wdata = chkw; g.gap = gap;
      gq.push_back(g);
   endtask

   task automatic exp_ack(bit is_data, logic err, logic [31:0] rdata, int len);
      ack_t a;
      a.is_data = is_data; a.err = err; a.rdata = rdata; a.len = len;
      aq.push_back(a);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_acks(int n, int budget);
      int seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (if_ack || d_ack) seen++;
         if (seen == n) return;
      end
      chk("ack_timeout", 32'(seen), 32'(n));
   endtask

   task automatic wait_mreq(int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (m_req) return;
      end
      chk("mreq_timeout", {31'd0, m_req}, 32'd1);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
      chk({tag, "_m_we"}, {31'd0, m_we}, 32'd0);
      chk({tag, "_m_addr"}, {2'd0, m_addr}, 32'd0);
      chk({tag, "_m_wdata"}, m_wdata, 32'd0);
      chk({tag, "_acks_errs"}, {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
      chk({tag, "_if_rdata"}, if_rdata, 32'd0);
      chk({tag, "_d_rdata"}, d_rdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder: raises m_ready in the ready_at-th cycle of m_req (0 = never).
   initial begin
      int mcyc = 0;
      forever begin
         @(negedge clk);
         if (m_req) begin
            mcyc++;
            m_ready = (ready_at != 0) && (mcyc == ready_at);
         end else begin
            mcyc = 0;
            m_ready = 1'b0;
         end
      end
   end

   // Monitor: compares every grant (m_req rise) and every ack against the scoreboard.
   initial begin
      logic   m_req_q = 1'b0;
      grant_t g;
      ack_t   a;
      forever begin
         @(negedge clk);
         if (m_req && !m_req_q) begin
            rise_cyc = cyc;
            if (gq.size() == 0) bad("unexpected_grant");
            else begin
               g = gq.pop_front();
               chk("grant_we", {31'd0, m_we}, {31'd0, g.we});
               chk("grant_addr", {2'd0, m_addr}, {2'd0, g.addr});
               if (g.chk_wdata) chk("grant_wdata", m_wdata, g.wdata);
               chk("grant_busy", {31'd0, busy}, 32'd1);
               if (g.gap >= 0) chk("grant_gap", 32'(cyc - last_ack_cyc), 32'(g.gap));
            end
         end
         if (if_ack || d_ack) begin
            last_ack_cyc = cyc;
            if (aq.size() == 0) bad("unexpected_ack");
            else begin
               a = aq.pop_front();
               chk("ack_port", {30'd0, if_ack, d_ack}, a.is_data ? 32'd1 : 32'd2);
               chk("ack_err", {30'd0, if_err, d_err}, a.is_data ? {31'd0, a.err} : {30'd0, a.err, 1'b0});
               chk("ack_rdata", a.is_data ? d_rdata : if_rdata, a.rdata);
               chk("ack_len", 32'(cyc - rise_cyc), 32'(a.len));
               chk("ack_mreq_low", {31'd0, m_req}, 32'd0);
            end
         end
         m_req_q = m_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b1;
      tick();

      // Tie after reset: fetch first, then strict alternation with one bubble cycle.
      ready_at = 1; m_rdata = 32'h1111_1111;
      if_addr = 30'h40; d_addr = 30'h50; d_we = 1'b0; d_wdata = 32'd0;
      exp_grant(1'b0, 30'h40, 32'd0, 1'b0, -1);
      exp_grant(1'b0, 30'h50, 32'd0, 1'b1, 1);
      exp_grant(1'b0, 30'h40, 32'd0, 1'b0, 1);
      exp_grant(1'b0, 30'h50, 32'd0, 1'b1, 1);
      for (int i = 0; i < 2; i++) begin
         exp_ack(1'b0, 1'b0, 32'h1111_1111, 1);
         exp_ack(1'b1, 1'b0, 32'h1111_1111, 1);
      end
      if_req = 1'b1; d_req = 1'b1;
      wait_acks(4, 40);
      if_req = 1'b0; d_req = 1'b0;
      repeat (2) tick();

      // Single fetch, ready on the third m_req cycle.
      ready_at = 3; m_rdata = 32'hE3A0_0001; if_addr = 30'h10;
      exp_grant(1'b0, 30'h10, 32'd0, 1'b0, -1);
      exp_ack(1'b0, 1'b0, 32'hE3A0_0001, 3);
      if_req = 1'b1;
      wait_acks(1, 20);
      if_req = 1'b0;
      repeat (2) tick();

      // Load 0x5, then a store that must leave d_rdata at 0x5.
      ready_at = 1; m_rdata = 32'h5; d_addr = 30'h30; d_we = 1'b0; d_wdata = 32'd0;
      exp_grant(1'b0, 30'h30, 32'd0, 1'b1, -1);
      exp_ack(1'b1, 1'b0, 32'h5, 1);
      d_req = 1'b1;
      wait_acks(1, 20);
      d_req = 1'b0;
      repeat (2) tick();
      m_rdata = 32'h99; d_addr = 30'h20; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
      exp_grant(1'b1, 30'h20, 32'hDEAD_BEEF, 1'b1, -1);
      exp_ack(1'b1, 1'b0, 32'h5, 1);
      d_req = 1'b1;
      wait_acks(1, 20);
      d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0;
      repeat (2) tick();

      // Timeout with MAX_WAIT=4, then ready exactly on the limit cycle.
      ready_at = 0; m_rdata = 32'h77; d_addr = 30'h24;
      exp_grant(1'b0, 30'h24, 32'd0, 1'b1, -1);
      exp_ack(1'b1, 1'b1, 32'd0, 4);
      d_req = 1'b1;
      wait_acks(1, 20);
      d_req = 1'b0;
      repeat (2) tick();
      ready_at = 4; m_rdata = 32'hCAFE_F00D; d_addr = 30'h28;
      exp_grant(1'b0, 30'h28, 32'd0, 1'b1, -1);
      exp_ack(1'b1, 1'b0, 32'hCAFE_F00D, 4);
      d_req = 1'b1;
      wait_acks(1, 20);
      d_req = 1'b0;
      repeat (2) tick();

      // Halted: only the data transaction may be issued.
      ready_at = 1; m_rdata = 32'h1234; d_addr = 30'h64; if_addr = 30'h60;
      exp_grant(1'b0, 30'h64, 32'd0, 1'b1, -1);
      exp_ack(1'b1, 1'b0, 32'h1234, 1);
      halted = 1'b1; if_req = 1'b1; d_req = 1'b1;
      wait_acks(1, 20);
      d_req = 1'b0;
      repeat (6) tick();
      if_req = 1'b0; halted = 1'b0;
      repeat (2) tick();

      // Halt raised during a fetch does not abort it.
      ready_at = 3; m_rdata = 32'hABCD; if_addr = 30'h70;
      exp_grant(1'b0, 30'h70, 32'd0, 1'b0, -1);
      exp_ack(1'b0, 1'b0, 32'hABCD, 3);
      if_req = 1'b1;
      wait_mreq(20);
      halted = 1'b1;
      wait_acks(1, 20);
      if_req = 1'b0; halted = 1'b0;
      repeat (2) tick();

      // Reset during a stalled load: no ack for it, then a fresh grant.
      ready_at = 0; m_rdata = 32'h5A5A_5A5A; d_addr = 30'h80;
      exp_grant(1'b0, 30'h80, 32'd0, 1'b1, -1);
      exp_grant(1'b0, 30'h80, 32'd0, 1'b1, -1);
      exp_ack(1'b1, 1'b0, 32'h5A5A_5A5A, 1);
      d_req = 1'b1;
      wait_mreq(20);
      tick();
      rst = 1'b0;
      tick();
      chk_all_zero("midreset");
      ready_at = 1;
      rst = 1'b1;
      tick();
      chk("regrant_rise", {31'd0, m_req}, 32'd1);
      wait_acks(1, 20);
      d_req = 1'b0;

      repeat (5) tick();
      chk("grants_left", 32'(gq.size()), 32'd0);
      chk("acks_left", 32'(aq.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
